// File: rtl/reg_file_pkg.sv
// Shared widths, clear-sequencer state encoding and a constant clog2 helper
// for the parametrised register file.
package reg_file_pkg;

   localparam int unsigned DefDataWidth = 16;
   localparam int unsigned DefAddrWidth = 5;
   localparam int unsigned DefNumRegs   = 16;

   typedef enum logic {
      StIdle  = 1'b0,
      StClear = 1'b1
   } clr_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((64'd1 << res) < 64'(value)) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer: walks a counter over every register index, one per cycle,
// after a clearReq pulse seen while idle.
module reg_file_clear_seq
   import reg_file_pkg::*;
#(
   parameter int unsigned NUM_REGS = DefNumRegs,
   parameter int unsigned CNT_W    = clog2(NUM_REGS) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clearReq,
   output logic             clrEn,
   output logic [CNT_W-1:0] clrAddr,
   output logic             clearBusy
);

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_REGS - 1);

   clr_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (clearReq) begin
                  state_q <= StClear;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StClear: begin
               // clearReq is ignored here, so a second pulse cannot restart the walk
               if (cnt_q == LastIdx) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign clrEn     = busy_q;
   assign clrAddr   = cnt_q;
   assign clearBusy = busy_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports, one write port, a
// registered observe port, optional write bypass, hardwired zero and clear engine.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned NUM_REGS   = DefNumRegs,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  controlRegWrite,
   input  logic [ADDR_WIDTH-1:0] writeReg,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic [ADDR_WIDTH-1:0] readReg1,
   input  logic [ADDR_WIDTH-1:0] readReg2,
   input  logic [ADDR_WIDTH-1:0] inr,
   input  logic                  clearReq,
   output logic [DATA_WIDTH-1:0] reg1Data,
   output logic [DATA_WIDTH-1:0] reg2Data,
   output logic [DATA_WIDTH-1:0] outvalue,
   output logic                  clearBusy
);

   localparam int unsigned CntW = clog2(NUM_REGS) + 1;

   logic                  clr_en;
   logic [CntW-1:0]       clr_addr;
   logic                  clear_busy;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_sel;
   logic [NUM_REGS-1:0]   clr_sel;
   logic                  wr_acc;
   logic [DATA_WIDTH-1:0] rd1_d, rd2_d, obs_d;
   logic [DATA_WIDTH-1:0] rd1_q, rd2_q, obs_q;

   reg_file_clear_seq #(
      .NUM_REGS (NUM_REGS),
      .CNT_W    (CntW)
   ) u_clear_seq (
      .clock     (clock),
      .reset     (reset),
      .clearReq  (clearReq),
      .clrEn     (clr_en),
      .clrAddr   (clr_addr),
      .clearBusy (clear_busy)
   );

   // Decoding only implemented indices makes out-of-range addresses read 0 and
   // drop writes without any separate range compare.
   always_comb begin
      wr_sel  = '0;
      clr_sel = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      obs_d   = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (!(ZERO_REG != 0 && i == 0)) begin
            if (controlRegWrite && !clear_busy && writeReg == ADDR_WIDTH'(i)) begin
               wr_sel[i] = 1'b1;
            end
            if (readReg1 == ADDR_WIDTH'(i)) rd1_d = regs_q[i];
            if (readReg2 == ADDR_WIDTH'(i)) rd2_d = regs_q[i];
            if (inr == ADDR_WIDTH'(i))      obs_d = regs_q[i];
         end
         if (clr_en && clr_addr == CntW'(i)) begin
            clr_sel[i] = 1'b1;
         end
      end
      wr_acc = |wr_sel;
      if (BYPASS != 0 && wr_acc && readReg1 == writeReg) rd1_d = writeData;
      if (BYPASS != 0 && wr_acc && readReg2 == writeReg) rd2_d = writeData;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_sel[i]) begin
               regs_q[i] <= '0;
            end else if (wr_sel[i]) begin
               regs_q[i] <= writeData;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd1_q <= '0;
         rd2_q <= '0;
         obs_q <= '0;
      end else begin
         rd1_q <= rd1_d;
         rd2_q <= rd2_d;
         obs_q <= obs_d;
      end
   end

   assign reg1Data  = rd1_q;
   assign reg2Data  = rd2_q;
   assign outvalue  = obs_q;
   assign clearBusy = clear_busy;

endmodule
